// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: CPU port, host port and the shared memory port.
// The slave view is the arbiter; the master view is whatever surrounds it.
interface dmem_arbiter_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rdata, host_rvalid,
        output mem_addr, mem_we, mem_din,
        input  mem_dout
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rdata, host_rvalid,
        input  mem_addr, mem_we, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU priority with a bounded host wait,
// one-cycle read data routed back to whichever requester issued the read.
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic         CLK,
    input  logic         reset,
    dmem_arbiter_if.slave bus
);
    localparam bit         BOUNDED    = (MAX_WAIT != 0);
    localparam logic [7:0] MAX_WAIT_8 = 8'(MAX_WAIT);

    logic       host_win;
    logic       cpu_gnt;
    logic       wait_expired;
    logic [7:0] wait_cnt;
    logic [1:0] rd_owner;

    // Grants are gated by reset so every output sits at its idle value while reset is low.
    assign wait_expired = BOUNDED && (wait_cnt >= MAX_WAIT_8);
    assign host_win     = reset & bus.host_req & (~bus.cpu_req | wait_expired);
    assign cpu_gnt      = reset & bus.cpu_req & ~host_win;

    assign bus.host_gnt  = host_win;
    assign bus.cpu_stall = reset & bus.cpu_req & ~cpu_gnt;

    always_comb begin
        bus.mem_addr = '0;
        bus.mem_we   = 1'b0;
        bus.mem_din  = '0;
        if (host_win) begin
            bus.mem_addr = bus.host_addr;
            bus.mem_we   = bus.host_we;
            bus.mem_din  = bus.host_wdata;
        end else if (cpu_gnt) begin
            bus.mem_addr = bus.cpu_addr;
            bus.mem_we   = bus.cpu_we;
            bus.mem_din  = bus.cpu_wdata;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 8'd0;
        end else if (bus.host_req && !host_win) begin
            if (wait_cnt != 8'hFF)
                wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    // Read-owner stage: tags the memory's registered output with its requester.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)
            rd_owner <= 2'b00;
        else
            rd_owner <= {host_win & ~bus.host_we, cpu_gnt & ~bus.cpu_we};
    end

    assign bus.cpu_rvalid  = rd_owner[0];
    assign bus.host_rvalid = rd_owner[1];
    assign bus.cpu_rdata   = bus.mem_dout;
    assign bus.host_rdata  = bus.mem_dout;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with MAX_WAIT=4, one with strict priority.
module tb_dmem_arbiter;
    logic CLK;
    logic reset;
    int   n_checks;
    int   n_errors;

    dmem_arbiter_if ifa ();
    dmem_arbiter_if ifb ();

    dmem_arbiter #(.MAX_WAIT(4)) u_dut_a (.CLK(CLK), .reset(reset), .bus(ifa));
    dmem_arbiter #(.MAX_WAIT(0)) u_dut_b (.CLK(CLK), .reset(reset), .bus(ifb));

    logic [15:0] mem_a [4096];
    logic [15:0] mem_b [4096];

    always @(posedge CLK) begin
        if (ifa.mem_we) mem_a[ifa.mem_addr] <= ifa.mem_din;
        ifa.mem_dout <= mem_a[ifa.mem_addr];
        if (ifb.mem_we) mem_b[ifb.mem_addr] <= ifb.mem_din;
        ifb.mem_dout <= mem_b[ifb.mem_addr];
    end

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        ifa.cpu_req = 0; ifa.cpu_we = 0; ifa.cpu_addr = '0; ifa.cpu_wdata = '0;
        ifa.host_req = 0; ifa.host_we = 0; ifa.host_addr = '0; ifa.host_wdata = '0;
        ifb.cpu_req = 0; ifb.cpu_we = 0; ifb.cpu_addr = '0; ifb.cpu_wdata = '0;
        ifb.host_req = 0; ifb.host_we = 0; ifb.host_addr = '0; ifb.host_wdata = '0;

        #2;
        chk("rst_cpu_rvalid", 16'(ifa.cpu_rvalid), 16'd0);
        chk("rst_host_rvalid", 16'(ifa.host_rvalid), 16'd0);
        chk("rst_host_gnt", 16'(ifa.host_gnt), 16'd0);
        chk("rst_cpu_stall", 16'(ifa.cpu_stall), 16'd0);
        chk("rst_mem_we", 16'(ifa.mem_we), 16'd0);
        chk("rst_mem_addr", 16'(ifa.mem_addr), 16'd0);
        chk("rst_mem_din", ifa.mem_din, 16'd0);
        chk("rst_wait_cnt", 16'(u_dut_a.wait_cnt), 16'd0);

        repeat (2) @(posedge CLK);
        #1 reset = 1'b1;
        #3;
        chk("rel_no_rvalid", 16'({ifa.cpu_rvalid, ifa.host_rvalid}), 16'd0);

        // CPU-only write then read
        cyc();
        ifa.cpu_req = 1; ifa.cpu_we = 1; ifa.cpu_addr = 12'h005; ifa.cpu_wdata = 16'h1234;
        #3;
        chk("cpu_wr_stall", 16'(ifa.cpu_stall), 16'd0);
        chk("cpu_wr_mem_we", 16'(ifa.mem_we), 16'd1);
        chk("cpu_wr_mem_addr", 16'(ifa.mem_addr), 16'h005);
        chk("cpu_wr_mem_din", ifa.mem_din, 16'h1234);
        cyc();
        ifa.cpu_we = 0;
        #3;
        chk("cpu_rd_stall", 16'(ifa.cpu_stall), 16'd0);
        chk("cpu_rd_mem_we", 16'(ifa.mem_we), 16'd0);
        chk("cpu_wr_no_rvalid", 16'(ifa.cpu_rvalid), 16'd0);
        cyc();
        ifa.cpu_req = 0;
        #3;
        chk("cpu_rvalid", 16'(ifa.cpu_rvalid), 16'd1);
        chk("cpu_rdata", ifa.cpu_rdata, 16'h1234);
        chk("cpu_rd_host_rvalid", 16'(ifa.host_rvalid), 16'd0);
        chk("idle_mem_addr", 16'(ifa.mem_addr), 16'd0);

        // Host-only write then read
        cyc();
        ifa.host_req = 1; ifa.host_we = 1; ifa.host_addr = 12'hFFF; ifa.host_wdata = 16'hBEEF;
        #3;
        chk("host_wr_gnt", 16'(ifa.host_gnt), 16'd1);
        chk("host_wr_mem_we", 16'(ifa.mem_we), 16'd1);
        chk("host_wr_mem_addr", 16'(ifa.mem_addr), 16'hFFF);
        cyc();
        ifa.host_we = 0;
        #3;
        chk("host_rd_gnt", 16'(ifa.host_gnt), 16'd1);
        cyc();
        ifa.host_req = 0;
        #3;
        chk("host_rvalid", 16'(ifa.host_rvalid), 16'd1);
        chk("host_rdata", ifa.host_rdata, 16'hBEEF);
        chk("host_rd_cpu_rvalid", 16'(ifa.cpu_rvalid), 16'd0);

        // Alternating reads: seed A and B, then CPU reads A, host reads B
        cyc();
        ifa.cpu_req = 1; ifa.cpu_we = 1; ifa.cpu_addr = 12'h010; ifa.cpu_wdata = 16'h0A0A;
        cyc();
        ifa.cpu_req = 0;
        ifa.host_req = 1; ifa.host_we = 1; ifa.host_addr = 12'h020; ifa.host_wdata = 16'h0B0B;
        #3;
        chk("seed_host_gnt", 16'(ifa.host_gnt), 16'd1);
        cyc();
        ifa.host_req = 0;
        ifa.cpu_req = 1; ifa.cpu_we = 0; ifa.cpu_addr = 12'h010;
        #3;
        chk("alt_cpu_stall", 16'(ifa.cpu_stall), 16'd0);
        cyc();
        ifa.cpu_req = 0;
        ifa.host_req = 1; ifa.host_we = 0; ifa.host_addr = 12'h020;
        #3;
        chk("alt_host_gnt", 16'(ifa.host_gnt), 16'd1);
        chk("alt_cpu_rvalid", 16'(ifa.cpu_rvalid), 16'd1);
        chk("alt_cpu_rdata", ifa.cpu_rdata, 16'h0A0A);
        chk("alt_host_rvalid_0", 16'(ifa.host_rvalid), 16'd0);
        cyc();
        ifa.host_req = 0;
        #3;
        chk("alt_host_rvalid", 16'(ifa.host_rvalid), 16'd1);
        chk("alt_host_rdata", ifa.host_rdata, 16'h0B0B);
        chk("alt_cpu_rvalid_0", 16'(ifa.cpu_rvalid), 16'd0);

        // Contention with MAX_WAIT=4: host wins every fifth cycle
        cyc();
        ifa.cpu_req = 1; ifa.cpu_we = 0; ifa.cpu_addr = 12'h010;
        ifa.host_req = 1; ifa.host_we = 0; ifa.host_addr = 12'h020;
        for (int c = 1; c <= 15; c++) begin
            logic g;
            g = (c % 5 == 0);
            #3;
            chk($sformatf("cont_host_gnt_%0d", c), 16'(ifa.host_gnt), 16'(g));
            chk($sformatf("cont_cpu_stall_%0d", c), 16'(ifa.cpu_stall), 16'(g));
            chk($sformatf("cont_wait_cnt_%0d", c), 16'(u_dut_a.wait_cnt), 16'((c - 1) % 5));
            chk($sformatf("cont_mem_addr_%0d", c), 16'(ifa.mem_addr), g ? 16'h020 : 16'h010);
            cyc();
        end
        ifa.cpu_req = 0;
        ifa.host_req = 0;

        // Strict priority with MAX_WAIT=0: host never wins, counter saturates
        ifb.cpu_req = 1; ifb.cpu_we = 0; ifb.cpu_addr = 12'h001;
        ifb.host_req = 1; ifb.host_we = 0; ifb.host_addr = 12'h002;
        for (int c = 1; c <= 300; c++) begin
            #3;
            chk($sformatf("strict_host_gnt_%0d", c), 16'(ifb.host_gnt), 16'd0);
            chk($sformatf("strict_wait_cnt_%0d", c), 16'(u_dut_b.wait_cnt),
                (c - 1 > 255) ? 16'd255 : 16'(c - 1));
            cyc();
        end
        #3;
        chk("strict_wait_sat", 16'(u_dut_b.wait_cnt), 16'd255);
        ifb.cpu_req = 0;
        ifb.host_req = 0;

        // Reset asserted during a granted CPU read
        cyc();
        ifa.cpu_req = 1; ifa.cpu_we = 0; ifa.cpu_addr = 12'h010;
        ifa.host_req = 1; ifa.host_we = 0; ifa.host_addr = 12'h020;
        cyc();
        #2;
        chk("mid_wait_cnt_pre", 16'(u_dut_a.wait_cnt), 16'd1);
        chk("mid_cpu_granted", 16'(ifa.cpu_stall), 16'd0);
        chk("mid_mem_addr_pre", 16'(ifa.mem_addr), 16'h010);
        #1 reset = 1'b0;
        #1;
        chk("mid_mem_addr", 16'(ifa.mem_addr), 16'd0);
        chk("mid_mem_we", 16'(ifa.mem_we), 16'd0);
        chk("mid_cpu_stall", 16'(ifa.cpu_stall), 16'd0);
        chk("mid_host_gnt", 16'(ifa.host_gnt), 16'd0);
        chk("mid_wait_cnt", 16'(u_dut_a.wait_cnt), 16'd0);
        ifa.host_req = 0;
        cyc();
        #3;
        chk("mid_cpu_rvalid", 16'(ifa.cpu_rvalid), 16'd0);
        chk("mid_host_rvalid", 16'(ifa.host_rvalid), 16'd0);
        cyc();
        reset = 1'b1;
        #3;
        chk("post_cpu_gnt", 16'(ifa.cpu_stall), 16'd0);
        chk("post_mem_addr", 16'(ifa.mem_addr), 16'h010);
        chk("post_no_rvalid", 16'(ifa.cpu_rvalid), 16'd0);
        cyc();
        ifa.cpu_req = 0;
        #3;
        chk("post_cpu_rvalid", 16'(ifa.cpu_rvalid), 16'd1);
        chk("post_cpu_rdata", ifa.cpu_rdata, 16'h0A0A);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
